mux_rr_scheduler: RTL and testbench
===================================

MUX_RR_SCHEDULER -- requirements
Module: mux_rr_scheduler

Interface
REQ-001 Parameter BURST_LEN, default 4, maximum beats per grant (legal 1..16).
REQ-002 Parameter TIMEOUT, default 15, stall cycles before forced release (legal 1..255; used only under REQ-027).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  8  per-requester request, bit n = requester n.
REQ-006 din  in  8  per-requester data bit, the 8:1 mux data inputs.
REQ-007 sel  out 3  registered mux select, index of granted requester.
REQ-008 gnt  out 8  registered one-hot grant; all-zero when idle.
REQ-009 out_valid  out 1  beat available on dout.
REQ-010 out_ready  in  1  downstream accepts beat.
REQ-011 dout  out 1  din[sel] while out_valid, else 0.
REQ-012 busy  out 1  high in GRANT state.
REQ-013 err  out 1  one-cycle timeout pulse.

Function
REQ-014 FSM SHALL have two states: IDLE and GRANT.
REQ-015 IDLE: when req != 0, winner = first set bit searching upward from ptr, wrapping 7->0; winner latched into sel/gnt, state -> GRANT.
REQ-016 Latency: req sampled high at edge N SHALL produce gnt, busy and out_valid high after edge N+1 (one cycle).
REQ-017 IDLE with req == 0: outputs unchanged at idle values, ptr unchanged.
REQ-018 GRANT: out_valid = 1, gnt one-hot at sel, dout = din[sel] combinationally.
REQ-019 Beat transfers on cycle where out_valid && out_ready; beat counter increments by 1.
REQ-020 Once asserted, out_valid SHALL stay high until a transfer; deassertion of req[sel] without a transfer SHALL NOT release the grant.
REQ-021 Release on a transfer when beat count reaches BURST_LEN or req[sel] == 0 in that cycle: state -> IDLE, gnt -> 0, out_valid -> 0, ptr -> (sel+1) mod 8, beat counter -> 0.
REQ-022 After release, at least one IDLE cycle precedes the next grant; released requester is lowest priority in that arbitration.
REQ-023 Only one requester active: it SHALL be regranted every second cycle pattern (GRANT burst, one IDLE, GRANT).
REQ-024 Beat counter width 5 bits; BURST_LEN == 1 releases on every transfer.

Reset
REQ-025 rst high at an edge: state IDLE, sel=0, gnt=0, out_valid=0, busy=0, err=0, ptr=0, beat and stall counters 0; dout=0.
REQ-026 Reset mid-burst SHALL drop grant at that edge, no release-side effects (err stays 0), priority restarts at requester 0.

Configuration
REQ-027 Macro MUX_SCHED_TIMEOUT_EN defined: 8-bit stall counter counts GRANT cycles with out_valid && !out_ready, clears on transfer; on reaching TIMEOUT, release per REQ-021 without a transfer and pulse err for one cycle.
REQ-028 Macro undefined: no stall counter, err tied 0, TIMEOUT ignored, grant held indefinitely on stall.

Structure
REQ-029 Package mux_sched_pkg SHALL hold state enum (IDLE, GRANT), NUM_REQ=8, SEL_W=3.
REQ-030 Data path SHALL be one sub-module mux8 (8:1 data mux, sel[2:0]) instantiated once for dout.

Verification
REQ-031 req=8'b0000_0100, out_ready=1, BURST_LEN=4 -> gnt=8'h04, sel=2 one cycle after req; 4 transfers; IDLE one cycle; regrant.
REQ-032 req=8'hFF held, out_ready=1, BURST_LEN=1 -> sel sequence 0,1,2..7,0 with one IDLE cycle between grants.
REQ-033 din=8'b1010_0000, req=8'h80, out_ready=0 for 5 cycles then 1 -> out_valid and dout=1 held stable 6 cycles, one transfer, release.
REQ-034 Grant to requester 3 at beat 2, rst=1 one cycle -> next cycle gnt=0, out_valid=0, err=0; req=8'h18 afterwards -> sel=3 (ptr=0).
REQ-035 MUX_SCHED_TIMEOUT_EN, TIMEOUT=15, req=8'h01, out_ready=0 -> err pulses exactly once 15 stall cycles after out_valid, gnt=0 next cycle; without macro err stays 0 after 100 cycles.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// mux_sched_pkg: shared types, sizes and the round-robin pick helper for
// the mux_rr_scheduler block.
package mux_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int BEAT_W  = 5;
  localparam int STALL_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set request bit at or above ptr_v, wrapping from the top index to 0.
  // Scanning offsets from high to low lets the smallest offset win last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [SEL_W-1:0]   ptr_v);
    logic [SEL_W-1:0] pick;
    logic [SEL_W-1:0] idx;
    pick = ptr_v;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr_v + SEL_W'(i);
      if (req_v[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_rr_scheduler_mux8.sv
// mux8: 8:1 single-bit data multiplexer steered by a 3-bit select.
module mux8
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  output logic               dout
);

  // Pure combinational selection of one data bit.
  always_comb begin
    dout = din[sel];
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin 8-requester scheduler driving an 8:1 data
// mux with a valid/ready beat interface and bounded bursts.
// Optional stall timeout enabled by defining MUX_SCHED_TIMEOUT_EN.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               dout,
  output logic               busy,
  output logic               err
);

  localparam logic [BEAT_W-1:0] BURST_W = BEAT_W'(BURST_LEN);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]    pick_s;
  logic                xfer_s;
  logic                last_s;
  logic                timeout_s;
  logic                release_s;
  logic                mux_s;

  assign pick_s    = rr_pick(req, ptr_q);
  assign xfer_s    = (state_q == GRANT) && out_ready;
  // Burst ends on the final beat or when the owner has withdrawn its request.
  assign last_s    = ((beat_q + 5'd1) == BURST_W) || !req[sel_q];
  assign release_s = (xfer_s && last_s) || timeout_s;

`ifdef MUX_SCHED_TIMEOUT_EN
  localparam logic [STALL_W-1:0] TIMEOUT_W = STALL_W'(TIMEOUT);
  logic [STALL_W-1:0] stall_q, stall_d;

  assign timeout_s = (state_q == GRANT) && !out_ready && ((stall_q + 8'd1) == TIMEOUT_W);

  // Stall counter register; cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 8'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  // Count consecutive stalled GRANT cycles; any transfer or new grant clears it.
  always_comb begin
    stall_d = stall_q;
    if (state_q == GRANT) begin
      if (release_s || out_ready) begin
        stall_d = 8'd0;
      end else begin
        stall_d = stall_q + 8'd1;
      end
    end else begin
      stall_d = 8'd0;
    end
  end
`else
  logic [STALL_W-1:0] unused_timeout_s;
  assign unused_timeout_s = STALL_W'(TIMEOUT);
  assign timeout_s        = 1'b0;
`endif

  // State and registered-output storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      ptr_q   <= 3'd0;
      beat_q  <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Next-state: leave IDLE on any request, leave GRANT on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req != 8'd0) begin
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: latch winner, count beats, release bookkeeping.
  always_comb begin
    sel_d  = sel_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    beat_d = beat_q;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 8'd0) begin
          sel_d  = pick_s;
          gnt_d  = 8'd1 << pick_s;
          beat_d = 5'd0;
        end else begin
          gnt_d  = 8'd0;
        end
      end
      GRANT: begin
        if (release_s) begin
          gnt_d  = 8'd0;
          ptr_d  = sel_q + 3'd1;
          beat_d = 5'd0;
          err_d  = timeout_s;
        end else if (xfer_s) begin
          beat_d = beat_q + 5'd1;
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        gnt_d = 8'd0;
      end
    endcase
  end

  mux8 u_mux8 (
    .din  (din),
    .sel  (sel_q),
    .dout (mux_s)
  );

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign busy      = (state_q == GRANT);
  assign out_valid = (state_q == GRANT);
  assign err       = err_q;
  assign dout      = (state_q == GRANT) ? mux_s : 1'b0;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: two instances (BURST_LEN 4 and 1) share inputs
// and are compared every cycle against a transaction-level reference model.
module tb_mux_rr_scheduler;

  localparam int TO = 15;
  localparam int BL [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] din;
  logic       out_ready;

  logic [2:0] sel_o   [2];
  logic [7:0] gnt_o   [2];
  logic       valid_o [2];
  logic       dout_o  [2];
  logic       busy_o  [2];
  logic       err_o   [2];

  int total = 0;
  int bad   = 0;

  // model state per instance
  bit m_grant [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_beats [2];
  int m_stall [2];
  bit m_err   [2];

  always #5 clk = ~clk;

  mux_rr_scheduler #(.BURST_LEN(4), .TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .req(req), .din(din), .sel(sel_o[0]), .gnt(gnt_o[0]),
    .out_valid(valid_o[0]), .out_ready(out_ready), .dout(dout_o[0]),
    .busy(busy_o[0]), .err(err_o[0]));

  mux_rr_scheduler #(.BURST_LEN(1), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .req(req), .din(din), .sel(sel_o[1]), .gnt(gnt_o[1]),
    .out_valid(valid_o[1]), .out_ready(out_ready), .dout(dout_o[1]),
    .busy(busy_o[1]), .err(err_o[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_grant[k] = 1'b0; m_owner[k] = 0; m_ptr[k] = 0;
      m_beats[k] = 0;    m_stall[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      if (!m_grant[k]) begin
        if (req != 8'd0) begin
          bit found = 1'b0;
          for (int i = 0; i < 8; i++) begin
            int c = (m_ptr[k] + i) % 8;
            if (!found && req[c]) begin
              found = 1'b1;
              m_owner[k] = c;
            end
          end
          m_grant[k] = 1'b1; m_beats[k] = 0; m_stall[k] = 0;
        end
      end else if (out_ready) begin
        m_beats[k]++;
        m_stall[k] = 0;
        if (m_beats[k] == BL[k] || !req[m_owner[k]]) begin
          m_grant[k] = 1'b0; m_ptr[k] = (m_owner[k] + 1) % 8; m_beats[k] = 0;
        end
      end else begin
`ifdef MUX_SCHED_TIMEOUT_EN
        m_stall[k]++;
        if (m_stall[k] == TO) begin
          m_grant[k] = 1'b0; m_ptr[k] = (m_owner[k] + 1) % 8;
          m_beats[k] = 0;    m_stall[k] = 0; m_err[k] = 1'b1;
        end
`endif
      end
    end
  endtask

  // Apply inputs mid-cycle, compare outputs against the model, then step it.
  task automatic cycle(input logic r, input logic [7:0] rq, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    rst = r; req = rq; din = d; out_ready = rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt%0d", k),   gnt_o[k],   m_grant[k] ? (32'd1 << m_owner[k]) : 32'd0);
      chk($sformatf("sel%0d", k),   sel_o[k],   m_owner[k]);
      chk($sformatf("valid%0d", k), valid_o[k], m_grant[k]);
      chk($sformatf("busy%0d", k),  busy_o[k],  m_grant[k]);
      chk($sformatf("dout%0d", k),  dout_o[k],  m_grant[k] ? d[m_owner[k]] : 1'b0);
      chk($sformatf("err%0d", k),   err_o[k],   m_err[k]);
    end
    model_step();
  endtask

  initial begin
    rst = 1'b1; req = 8'd0; din = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // reset state
    cycle(1'b0, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 8'hFF, 1'b1);

    // single requester 2: grant one cycle later, burst, one idle, regrant
    cycle(1'b0, 8'h04, 8'h04, 1'b1);
    @(posedge clk); #1;
    chk("r31_gnt", gnt_o[0], 32'h04);
    chk("r31_sel", sel_o[0], 32'd2);
    repeat (12) cycle(1'b0, 8'h04, 8'($urandom), 1'b1);

    // all requesting: rotating selects
    repeat (40) cycle(1'b0, 8'hFF, 8'($urandom), 1'b1);

    // drain, then stalled grant to requester 7 with a single transfer
    repeat (6) cycle(1'b0, 8'h00, 8'h00, 1'b1);
    repeat (6) cycle(1'b0, 8'h80, 8'hA0, 1'b0);
    chk("r33_dout", dout_o[0], 32'd1);
    cycle(1'b0, 8'h00, 8'hA0, 1'b1);
    @(posedge clk); #1;
    chk("r33_rel", gnt_o[0], 32'h00);

    // reset mid-burst of requester 3
    cycle(1'b1, 8'h00, 8'h00, 1'b0);
    cycle(1'b0, 8'h08, 8'h08, 1'b0);
    cycle(1'b0, 8'h08, 8'h08, 1'b1);
    cycle(1'b0, 8'h08, 8'h08, 1'b1);
    cycle(1'b1, 8'h08, 8'h08, 1'b1);
    @(posedge clk); #1;
    chk("r34_gnt", gnt_o[0], 32'h00);
    chk("r34_err", err_o[0], 32'd0);
    cycle(1'b0, 8'h18, 8'h00, 1'b1);
    @(posedge clk); #1;
    chk("r34_sel", sel_o[0], 32'd3);

    // randomized traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      logic [7:0] rq;
      rq = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom & $urandom);
      cycle(($urandom_range(0, 60) == 0), rq, 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    // long stall on requester 0 (timeout behaviour depends on build)
    repeat (6) cycle(1'b0, 8'h00, 8'h00, 1'b1);
    repeat (40) cycle(1'b0, 8'h01, 8'h01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
